// File: rtl/interboard_tx_scheduler_pkg.sv
`default_nettype none
//==============================================================================
// Module   : interboard_tx_scheduler_pkg
// Purpose  : Message codes, message layout and FSM encodings for the link TX path
// Revision : 1.0 - initial release
//==============================================================================
package interboard_tx_scheduler_pkg;

    localparam int c_MSG_WIDTH = 8;

    typedef enum logic [2:0] {
        MSG_NOP   = 3'd0,
        MSG_MOVE  = 3'd1,
        MSG_SCORE = 3'd2,
        MSG_SYNC  = 3'd3,
        MSG_RESET = 3'd4,
        MSG_ACK   = 3'd5
    } msg_type_e;

    typedef struct packed {
        logic [2:0] msg_type;
        logic [4:0] number;
    } msg_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/interboard_tx_fifo.sv
`default_nettype none
//==============================================================================
// Module   : interboard_tx_fifo
// Purpose  : Small synchronous FIFO with flush; head entry is visible combinationally
// Revision : 1.0 - initial release
//==============================================================================
module interboard_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // A pop frees the slot in the same cycle, so a full FIFO may still take a push.
    assign w_do_push = push && !flush && (!full || pop);
    assign w_do_pop  = pop && !flush && !empty;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign head_data = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/interboard_tx_scheduler.sv
`default_nettype none
//==============================================================================
// Module   : interboard_tx_scheduler
// Purpose  : Round-robin queueing of two requesters and paced, retried issue to the link
// Revision : 1.0 - initial release
//==============================================================================
module interboard_tx_scheduler
    import interboard_tx_scheduler_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 1023,
    parameter int MAX_RETRY  = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       interboard_rst,
    input  logic       req0_valid,
    input  logic [2:0] req0_msg_type,
    input  logic [4:0] req0_number,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [2:0] req1_msg_type,
    input  logic [4:0] req1_number,
    output logic       req1_ready,
    input  logic       inter_ready,
    output logic       transmit,
    output logic       ctrl_en,
    output logic [2:0] ctrl_msg_type,
    output logic [4:0] ctrl_number,
    output logic       busy,
    output logic       tx_timeout,
    output logic       tx_drop
);

    localparam int c_TW = (TIMEOUT > 0)    ? $clog2(TIMEOUT + 1)    : 1;
    localparam int c_RW = (MAX_RETRY > 0)  ? $clog2(MAX_RETRY + 1)  : 1;
    localparam int c_GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [c_TW-1:0] c_TIMEOUT   = c_TW'(TIMEOUT);
    localparam logic [c_RW-1:0] c_MAX_RETRY = c_RW'(MAX_RETRY);
    localparam logic [c_GW-1:0] c_GAP_LAST  = (GAP_CYCLES > 0) ? c_GW'(GAP_CYCLES - 1) : '0;

    state_t          r_state;
    logic [c_TW-1:0] r_wait_cnt;
    logic [c_RW-1:0] r_retry;
    logic [c_GW-1:0] r_gap_cnt;
    logic            r_rr_ptr;

    logic            w_grant0;
    logic            w_grant1;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_in_wait;
    logic            w_link_event;
    logic            w_timeout;
    logic            w_retry_left;
    msg_t            w_push_msg;
    msg_t            w_head;

    // r_rr_ptr names the requester preferred when both are valid.
    assign w_grant0   = req0_valid && (!req1_valid || !r_rr_ptr);
    assign w_grant1   = req1_valid && (!req0_valid ||  r_rr_ptr);
    assign req0_ready = w_grant0 && !w_full && !interboard_rst;
    assign req1_ready = w_grant1 && !w_full && !interboard_rst;
    assign w_push     = req0_ready || req1_ready;
    assign w_push_msg = req1_ready ? {req1_msg_type, req1_number} : {req0_msg_type, req0_number};

    assign w_in_wait    = (r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_DONE);
    assign w_link_event = ((r_state == ST_WAIT_BUSY) && !inter_ready) ||
                          ((r_state == ST_WAIT_DONE) &&  inter_ready);
    assign w_timeout    = w_in_wait && !w_link_event && (r_wait_cnt == c_TIMEOUT);
    assign w_retry_left = (r_retry < c_MAX_RETRY);
    assign w_pop        = !interboard_rst &&
                          (((r_state == ST_WAIT_DONE) && inter_ready) || (w_timeout && !w_retry_left));

    assign busy = !w_empty || (r_state != ST_IDLE);

    interboard_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_MSG_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (interboard_rst),
        .push      (w_push),
        .push_data (w_push_msg),
        .pop       (w_pop),
        .head_data (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_wait_cnt    <= '0;
            r_retry       <= '0;
            r_gap_cnt     <= '0;
            r_rr_ptr      <= 1'b0;
            transmit      <= 1'b0;
            ctrl_en       <= 1'b0;
            ctrl_msg_type <= '0;
            ctrl_number   <= '0;
            tx_timeout    <= 1'b0;
            tx_drop       <= 1'b0;
        end else if (interboard_rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_retry    <= '0;
            r_gap_cnt  <= '0;
            transmit   <= 1'b0;
            ctrl_en    <= 1'b0;
            tx_timeout <= 1'b0;
            tx_drop    <= 1'b0;
        end else begin
            transmit   <= 1'b0;
            ctrl_en    <= 1'b0;
            tx_timeout <= 1'b0;
            tx_drop    <= 1'b0;
            if (w_push) r_rr_ptr <= req0_ready;

            case (r_state)
                // Strobes are set on entry so they are high during the ISSUE cycle.
                ST_IDLE: begin
                    if (!w_empty && inter_ready) begin
                        r_state       <= ST_ISSUE;
                        transmit      <= 1'b1;
                        ctrl_en       <= 1'b1;
                        ctrl_msg_type <= w_head.msg_type;
                        ctrl_number   <= w_head.number;
                    end
                end
                ST_ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY, ST_WAIT_DONE: begin
                    if (w_link_event) begin
                        r_wait_cnt <= '0;
                        if (r_state == ST_WAIT_BUSY) begin
                            r_state <= ST_WAIT_DONE;
                        end else begin
                            r_retry   <= '0;
                            r_gap_cnt <= '0;
                            r_state   <= ST_GAP;
                        end
                    end else if (w_timeout) begin
                        tx_timeout <= 1'b1;
                        r_wait_cnt <= '0;
                        if (w_retry_left) begin
                            r_retry <= r_retry + 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            tx_drop   <= 1'b1;
                            r_retry   <= '0;
                            r_gap_cnt <= '0;
                            r_state   <= ST_GAP;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt >= c_GAP_LAST) r_state   <= ST_IDLE;
                    else                         r_gap_cnt <= r_gap_cnt + 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
